fifo_replay_reader: RTL and testbench
=====================================

Name: fifo_replay_reader

Overview:
- Read-side controller for the label sample FIFO (block-RAM backed, 1-cycle registered read port, mark/read-reset replay pointer).
- Drives the FIFO's pop, mark and read-rewind controls and compensates for the RAM read latency.
- Streams a frame of FRAME entries to a downstream valid/ready consumer, replaying the same frame a programmable number of passes (e.g. one pass per classifier stage) without re-writing the FIFO.

Parameters:
- DATA_W, 16, width of FIFO entries and output data.
- LEN_W, 10, width of frame-length field; max frame = 2^LEN_W-1 entries.
- PASS_W, 4, width of pass-count field.
- READ_LAT, 1, cycles from pop assertion to the corresponding entry being valid on i_fifo_front.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- i_start  in  1  one-cycle start pulse; sampled only in IDLE.
- i_frame_len  in  LEN_W  entries per pass; latched on accepted start.
- i_num_pass  in  PASS_W  number of passes; latched on accepted start.
- o_fifo_pop  out  1  pop request to FIFO.
- o_fifo_mark  out  1  one-cycle pulse; FIFO marks current read pointer.
- o_fifo_read_rst  out  1  one-cycle pulse; FIFO rewinds read pointer to mark.
- i_fifo_front  in  DATA_W  FIFO read data.
- i_fifo_empty  in  1  FIFO empty flag.
- o_data  out  DATA_W  output entry.
- o_valid  out  1  output valid.
- i_ready  in  1  downstream ready; transfer when o_valid & i_ready.
- o_last  out  1  qualifies last entry of each pass.
- o_pass_last  out  1  qualifies last entry of final pass.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; skid buffer empty.
- States: IDLE -> MARK -> STREAM -> (REWIND -> STREAM)* -> DRAIN -> DONE -> IDLE.
- IDLE: on i_start, latch len/pass. If len==0 or pass==0, go directly to DONE with no FIFO control activity. Otherwise go to MARK.
- MARK: o_fifo_mark=1 for exactly one cycle, then STREAM.
- STREAM: o_fifo_pop = ~i_fifo_empty & (credits>0) & (pop_cnt<len).
  - Each pop pushes a tag into a READ_LAT-deep valid shift line.
  - When the tag emerges, i_fifo_front is written into the skid buffer, depth READ_LAT+1.
  - Credits = buffer depth − (occupancy + in-flight). Data is never dropped under any backpressure.
- Pass boundary: pop_cnt==len and pass_cnt<num_pass-1 -> REWIND.
  - Wait until in-flight==0.
  - o_fifo_read_rst=1 for one cycle.
  - Next cycle: pass_cnt+1, pop_cnt=0, back to STREAM. No pop is issued in the read_rst cycle.
- Final pass: pop_cnt==len -> DRAIN until the buffer is empty and the last transfer completes -> DONE.
- DONE: o_done=1 for one cycle; o_busy drops the same cycle; -> IDLE.
- o_last is set on the entry whose output index within the pass equals len-1. o_pass_last additionally requires the final pass. An output-side counter tracks this, independent of the pop counter.
- Output follows AXI-style rules: o_data/o_valid/o_last are stable while o_valid & ~i_ready.
- Empty FIFO mid-pass: pops stall, no timeout, state held.
- i_start while busy: ignored.
- Reset mid-operation:
  - Aborts immediately to IDLE and clears the buffer.
  - No read_rst is issued.
  - The FIFO is reset by the same rst_n.
- Counters: pop_cnt and out_cnt are LEN_W wide; pass_cnt is PASS_W wide; none wrap within a job.

Optional Feature:
- Macro FIFO_REPLAY_READER_FLUSH_EN.
- When defined: adds output port o_fifo_flush (1 bit), pulsed high in the DONE cycle, so the FIFO is emptied after the final pass.
- When undefined: the port is absent; FIFO contents beyond the consumed pointer are retained.

Decomposition:
- Package fifo_replay_pkg:
  - state enum (IDLE, MARK, STREAM, REWIND, DRAIN, DONE);
  - default width localparams;
  - a function computing skid depth from READ_LAT.
- One sub-module, replay_skid_buf: parameterised depth, DATA_W+1 wide (data plus last flag), valid/ready both sides, occupancy output for credit accounting.

Test Plan:
- Basic replay: FIFO preloaded 0x11,0x22,0x33,0x44; len=4, pass=2, ready=1.
  - Output sequence is 11,22,33,44,11,22,33,44.
  - o_last on both 0x44; o_pass_last on the second only.
  - Exactly one mark pulse, one read_rst pulse, one done pulse.
- Backpressure: same setup, i_ready low for 5 cycles after the first transfer.
  - No pops issued once credits reach 0.
  - Output stable while stalled.
  - Full sequence intact, no duplicates.
- Empty stall: FIFO holds 2 of 4 entries at start; the remaining 2 are pushed 10 cycles later.
  - Pops pause while i_fifo_empty=1.
  - Output resumes with the correct order and o_last on the 4th entry.
- Degenerate: len=0 or pass=0 -> o_done 1 cycle after start; no pop, mark or read_rst activity. A start pulse while busy is ignored (single done).
- Reset mid-pass: rst_n low for 1 cycle during pass 1 -> all outputs 0 next cycle; a new start then runs a complete correct job.
- Flush macro defined: o_fifo_flush is high exactly in the o_done cycle; undefined build compiles without the port.

Source files
------------

// File: rtl/fifo_replay_pkg.sv
// Shared constants for the FIFO replay reader: state codes, default widths and
// the skid-depth rule that ties the output buffer to the FIFO read latency.
package fifo_replay_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_LEN_W    = 10;
  localparam int DEF_PASS_W   = 4;
  localparam int DEF_READ_LAT = 1;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_MARK   = 3'd1;
  localparam logic [STATE_W-1:0] ST_STREAM = 3'd2;
  localparam logic [STATE_W-1:0] ST_REWIND = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

  // One slot per in-flight read plus one so a stalled consumer never loses data.
  function automatic int skid_depth(input int read_lat);
    return read_lat + 1;
  endfunction

endpackage

// File: rtl/fifo_replay_reader_skid.sv
// Small circular buffer between the FIFO read port and the consumer; the
// occupancy output feeds the reader's credit accounting.
module replay_skid_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign occupancy = count_reg;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Head entry is held in place until accepted, which keeps the output stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= in_data;
        wr_ptr_reg          <= bump(wr_ptr_reg);
      end
      if (pop) rd_ptr_reg <= bump(rd_ptr_reg);
      if (push && !pop) count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/fifo_replay_reader.sv
// Read-side controller that replays one FIFO frame for several passes.
// Define FIFO_REPLAY_READER_FLUSH_EN to add o_fifo_flush, pulsed with o_done.
module fifo_replay_reader
  import fifo_replay_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int PASS_W   = DEF_PASS_W,
  parameter int READ_LAT = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_frame_len,
  input  logic [PASS_W-1:0] i_num_pass,
  output logic              o_fifo_pop,
  output logic              o_fifo_mark,
  output logic              o_fifo_read_rst,
  input  logic [DATA_W-1:0] i_fifo_front,
  input  logic              i_fifo_empty,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_pass_last,
  output logic              o_busy,
`ifdef FIFO_REPLAY_READER_FLUSH_EN
  output logic              o_fifo_flush,
`endif
  output logic              o_done
);

  localparam int DEPTH = skid_depth(READ_LAT);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [STATE_W-1:0] state_reg, state_next;
  logic [LEN_W-1:0]   len_reg;
  logic [PASS_W-1:0]  num_pass_reg;
  logic [LEN_W-1:0]   pop_cnt_reg;
  logic [PASS_W-1:0]  pass_cnt_reg;
  logic [LEN_W-1:0]   out_cnt_reg;
  logic [READ_LAT-1:0] line_reg;

  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   occupancy;
  logic               credit_ok;
  logic               pass_final;
  logic               pop;
  logic               start_accept;
  logic               rewind_fire;
  logic               xfer;
  logic               skid_in_ready;
  logic [DATA_W:0]    skid_out;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LAT; i++) inflight = inflight + CNT_W'(line_reg[i]);
  end

  assign credit_ok    = ({1'b0, occupancy} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH);
  assign pass_final   = (pass_cnt_reg == num_pass_reg - 1'b1);
  assign pop          = (state_reg == ST_STREAM) & ~i_fifo_empty & credit_ok &
                        skid_in_ready & (pop_cnt_reg < len_reg);
  assign start_accept = (state_reg == ST_IDLE) & i_start;
  assign rewind_fire  = (state_reg == ST_REWIND) & (inflight == '0);
  assign xfer         = o_valid & i_ready;

  // Each entry carries a final-pass flag; all writes of a pass land before the
  // rewind bumps pass_cnt, so the flag is exact even while older entries drain.
  replay_skid_buf #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1),
    .CNT_W (CNT_W)
  ) skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (line_reg[READ_LAT-1]),
    .in_ready  (skid_in_ready),
    .in_data   ({pass_final, i_fifo_front}),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .out_data  (skid_out),
    .occupancy (occupancy)
  );

  assign o_data          = skid_out[DATA_W-1:0];
  assign o_last          = o_valid & (out_cnt_reg == len_reg - 1'b1);
  assign o_pass_last     = o_last & skid_out[DATA_W];
  assign o_fifo_pop      = pop;
  assign o_fifo_mark     = (state_reg == ST_MARK);
  assign o_fifo_read_rst = rewind_fire;
  assign o_busy          = (state_reg != ST_IDLE) & (state_reg != ST_DONE);
  assign o_done          = (state_reg == ST_DONE);
`ifdef FIFO_REPLAY_READER_FLUSH_EN
  assign o_fifo_flush    = (state_reg == ST_DONE);
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (i_start) state_next = (i_frame_len == '0 || i_num_pass == '0) ? ST_DONE : ST_MARK;
      ST_MARK:   state_next = ST_STREAM;
      ST_STREAM: if (pop_cnt_reg == len_reg) state_next = pass_final ? ST_DRAIN : ST_REWIND;
      ST_REWIND: if (inflight == '0) state_next = ST_STREAM;
      ST_DRAIN:  if (occupancy == '0 && inflight == '0) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      len_reg      <= '0;
      num_pass_reg <= '0;
      pop_cnt_reg  <= '0;
      pass_cnt_reg <= '0;
      out_cnt_reg  <= '0;
      line_reg     <= '0;
    end else begin
      state_reg <= state_next;
      line_reg  <= READ_LAT'({line_reg, pop});
      if (start_accept) begin
        len_reg      <= i_frame_len;
        num_pass_reg <= i_num_pass;
        pop_cnt_reg  <= '0;
        pass_cnt_reg <= '0;
        out_cnt_reg  <= '0;
      end else begin
        if (rewind_fire) begin
          pop_cnt_reg  <= '0;
          pass_cnt_reg <= pass_cnt_reg + 1'b1;
        end else if (pop) begin
          pop_cnt_reg <= pop_cnt_reg + 1'b1;
        end
        if (xfer) out_cnt_reg <= o_last ? '0 : out_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_replay_reader.sv
// Bench for fifo_replay_reader: a behavioural mark/rewind FIFO feeds the DUT and
// the streamed output is compared against the frame repeated pass by pass.
`timescale 1ns/1ps
module tb_fifo_replay_reader;
  localparam int DW = 16;
  localparam int LW = 10;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [LW-1:0] i_frame_len = '0;
  logic [PW-1:0] i_num_pass = '0;
  logic          i_ready = 1'b1;
  logic          o_fifo_pop, o_fifo_mark, o_fifo_read_rst;
  logic [DW-1:0] o_data;
  logic          o_valid, o_last, o_pass_last, o_busy, o_done;
  logic [DW-1:0] front;
  logic          fifo_empty;
`ifdef FIFO_REPLAY_READER_FLUSH_EN
  logic          o_fifo_flush;
`endif

  always #5 clk = ~clk;

  fifo_replay_reader dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_frame_len(i_frame_len),
    .i_num_pass(i_num_pass), .o_fifo_pop(o_fifo_pop), .o_fifo_mark(o_fifo_mark),
    .o_fifo_read_rst(o_fifo_read_rst), .i_fifo_front(front), .i_fifo_empty(fifo_empty),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_pass_last(o_pass_last), .o_busy(o_busy),
`ifdef FIFO_REPLAY_READER_FLUSH_EN
    .o_fifo_flush(o_fifo_flush),
`endif
    .o_done(o_done)
  );

  // FIFO model: registered read, mark/rewind pointer, reset by the same rst_n.
  logic [DW-1:0] fmem [256];
  logic [7:0]    rd_p, wr_p, mk_p;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_data = '0;
  assign fifo_empty = (rd_p == wr_p);

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_p <= '0; wr_p <= '0; mk_p <= '0; front <= '0;
    end else begin
      if (push_en) begin
        fmem[wr_p] <= push_data;
        wr_p <= wr_p + 8'd1;
      end
      if (o_fifo_mark) mk_p <= rd_p;
      if (o_fifo_read_rst) rd_p <= mk_p;
      else if (o_fifo_pop && !fifo_empty) begin
        front <= fmem[rd_p];
        rd_p <= rd_p + 8'd1;
      end
`ifdef FIFO_REPLAY_READER_FLUSH_EN
      if (o_fifo_flush) rd_p <= wr_p + (push_en ? 8'd1 : 8'd0);
`endif
    end
  end

  // Monitor: records transfers and protocol event counts mid-cycle.
  logic [17:0] got_q[$];
  logic [17:0] cur, prev_out;
  logic        prev_stall;
  int pop_total = 0, mark_total = 0, rst_total = 0, done_total = 0;
  int outst = 0, credit_viol = 0, stall_viol = 0, empty_pop_viol = 0, rst_pop_viol = 0;
  int flush_viol = 0;
  assign cur = {o_pass_last, o_last, o_data};

  always @(negedge clk) begin
    if (!rst_n) begin
      outst <= 0;
      prev_stall <= 1'b0;
    end else begin
      pop_total  <= pop_total + int'(o_fifo_pop);
      mark_total <= mark_total + int'(o_fifo_mark);
      rst_total  <= rst_total + int'(o_fifo_read_rst);
      done_total <= done_total + int'(o_done);
      if (o_fifo_pop && fifo_empty) empty_pop_viol <= empty_pop_viol + 1;
      if (o_fifo_pop && o_fifo_read_rst) rst_pop_viol <= rst_pop_viol + 1;
      if (prev_stall && (!o_valid || cur !== prev_out)) stall_viol <= stall_viol + 1;
      prev_stall <= o_valid && !i_ready;
      prev_out <= cur;
      if (o_valid && i_ready) got_q.push_back(cur);
      outst <= outst + int'(o_fifo_pop) - int'(o_valid && i_ready);
      if (outst + int'(o_fifo_pop) - int'(o_valid && i_ready) > 2) credit_viol <= credit_viol + 1;
`ifdef FIFO_REPLAY_READER_FLUSH_EN
      if (o_fifo_flush !== o_done) flush_viol <= flush_viol + 1;
`endif
    end
  end

  int checks = 0, failures = 0;
  logic [DW-1:0] frame [16];
  logic [17:0]   exp_q[$];

  // Reference: the frame repeated once per pass, last/pass_last from the index.
  task automatic build_expected(input int len, input int npass);
    exp_q.delete();
    for (int p = 0; p < npass; p++)
      for (int i = 0; i < len; i++)
        exp_q.push_back({1'((i == len - 1) && (p == npass - 1)), 1'(i == len - 1), frame[i]});
  endtask

  task automatic push_frame(input int from, input int n);
    for (int i = from; i < from + n; i++) begin
      @(posedge clk); #1;
      push_en = 1'b1; push_data = frame[i];
    end
    @(posedge clk); #1;
    push_en = 1'b0;
  endtask

  task automatic start_job(input int len, input int npass);
    @(posedge clk); #1;
    i_start = 1'b1; i_frame_len = LW'(len); i_num_pass = PW'(npass);
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (o_done) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (rnd) i_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({o_valid, o_data, o_last, o_pass_last, o_busy, o_done, o_fifo_pop, o_fifo_mark, o_fifo_read_rst} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b data=%h busy=%b done=%b pop=%b required all 0",
               o_valid, o_data, o_busy, o_done, o_fifo_pop);
    end
  endtask

  task automatic test_basic;
    int base, m0, r0, d0, p0;
    bit ok;
    frame[0] = 16'h11; frame[1] = 16'h22; frame[2] = 16'h33; frame[3] = 16'h44;
    push_frame(0, 4);
    base = got_q.size(); m0 = mark_total; r0 = rst_total; d0 = done_total; p0 = pop_total;
    start_job(4, 2);
    wait_done(300, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done_timeout got no done required done"); end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got %b required 0", o_busy); end
    @(posedge clk); #1;
    build_expected(4, 2);
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL basic_count got %0d required %0d", got_q.size() - base, exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[base + i] !== exp_q[i]) begin
          failures++; $display("FAIL basic_seq idx %0d got %h required %h", i, got_q[base + i], exp_q[i]); break;
        end
    checks++;
    if (mark_total - m0 != 1) begin failures++; $display("FAIL basic_marks got %0d required 1", mark_total - m0); end
    checks++;
    if (rst_total - r0 != 1) begin failures++; $display("FAIL basic_read_rst got %0d required 1", rst_total - r0); end
    checks++;
    if (done_total - d0 != 1) begin failures++; $display("FAIL basic_dones got %0d required 1", done_total - d0); end
    checks++;
    if (pop_total - p0 != 8) begin failures++; $display("FAIL basic_pops got %0d required 8", pop_total - p0); end
    $display("basic replay len=4 pass=2 transfers=%0d", got_q.size() - base);
  endtask

  task automatic test_backpressure;
    int base, sv0, cv0, p0;
    bit ok, seen;
    frame[0] = 16'hA1; frame[1] = 16'hB2; frame[2] = 16'hC3; frame[3] = 16'hD4;
    push_frame(0, 4);
    base = got_q.size(); sv0 = stall_viol; cv0 = credit_viol; p0 = pop_total;
    start_job(4, 2);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (got_q.size() > base) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_first_xfer_timeout got none required one"); end
    i_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 i_ready = 1'b1;
    wait_done(300, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_done_timeout got no done required done"); end
    @(posedge clk); #1;
    build_expected(4, 2);
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL bp_count got %0d required %0d", got_q.size() - base, exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[base + i] !== exp_q[i]) begin
          failures++; $display("FAIL bp_seq idx %0d got %h required %h", i, got_q[base + i], exp_q[i]); break;
        end
    checks++;
    if (stall_viol != sv0) begin failures++; $display("FAIL bp_stable got %0d changes required 0", stall_viol - sv0); end
    checks++;
    if (credit_viol != cv0) begin failures++; $display("FAIL bp_credit got %0d overruns required 0", credit_viol - cv0); end
    checks++;
    if (pop_total - p0 != 8) begin failures++; $display("FAIL bp_pops got %0d required 8", pop_total - p0); end
    $display("backpressure stall=5 transfers=%0d", got_q.size() - base);
  endtask

  task automatic test_empty_stall;
    int base, e0, rp0;
    bit ok;
    for (int i = 0; i < 4; i++) frame[i] = 16'($urandom);
    push_frame(0, 2);
    base = got_q.size(); e0 = empty_pop_viol; rp0 = rst_pop_viol;
    start_job(4, 2);
    repeat (10) @(posedge clk);
    push_frame(2, 2);
    wait_done(300, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL empty_done_timeout got no done required done"); end
    @(posedge clk); #1;
    build_expected(4, 2);
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL empty_count got %0d required %0d", got_q.size() - base, exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[base + i] !== exp_q[i]) begin
          failures++; $display("FAIL empty_seq idx %0d got %h required %h", i, got_q[base + i], exp_q[i]); break;
        end
    checks++;
    if (empty_pop_viol != e0) begin failures++; $display("FAIL empty_pop got %0d pops while empty required 0", empty_pop_viol - e0); end
    checks++;
    if (rst_pop_viol != rp0) begin failures++; $display("FAIL rewind_pop got %0d required 0", rst_pop_viol - rp0); end
    $display("empty stall len=4 pass=2 transfers=%0d", got_q.size() - base);
  endtask

  task automatic test_degenerate(input int len, input int npass);
    int p0, m0, r0;
    p0 = pop_total; m0 = mark_total; r0 = rst_total;
    start_job(len, npass);
    checks++;
    if (o_done !== 1'b1) begin failures++; $display("FAIL degen_done len=%0d pass=%0d got %b required 1", len, npass, o_done); end
    @(posedge clk); #1;
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      failures++; $display("FAIL degen_idle got done=%b busy=%b required 0 0", o_done, o_busy);
    end
    checks++;
    if (pop_total != p0 || mark_total != m0 || rst_total != r0) begin
      failures++; $display("FAIL degen_ctrl got pops=%0d marks=%0d rsts=%0d required 0 0 0",
                           pop_total - p0, mark_total - m0, rst_total - r0);
    end
    $display("degenerate len=%0d pass=%0d", len, npass);
  endtask

  task automatic test_start_while_busy;
    int base, d0;
    bit ok;
    for (int i = 0; i < 3; i++) frame[i] = 16'($urandom);
    push_frame(0, 3);
    base = got_q.size(); d0 = done_total;
    start_job(3, 1);
    start_job(1, 1);
    wait_done(300, 1'b0, ok);
    repeat (6) @(posedge clk);
    #1;
    build_expected(3, 1);
    checks++;
    if (done_total - d0 != 1) begin failures++; $display("FAIL busy_start_dones got %0d required 1", done_total - d0); end
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL busy_start_count got %0d required %0d", got_q.size() - base, exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[base + i] !== exp_q[i]) begin
          failures++; $display("FAIL busy_start_seq idx %0d got %h required %h", i, got_q[base + i], exp_q[i]); break;
        end
    $display("start while busy ignored, transfers=%0d", got_q.size() - base);
  endtask

  task automatic test_reset_mid;
    int base;
    bit ok, seen;
    for (int i = 0; i < 4; i++) frame[i] = 16'($urandom);
    push_frame(0, 4);
    base = got_q.size();
    start_job(4, 2);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (got_q.size() >= base + 5) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({o_valid, o_data, o_last, o_pass_last, o_busy, o_done, o_fifo_pop, o_fifo_mark, o_fifo_read_rst} !== '0) begin
      failures++; $display("FAIL reset_mid_outputs got valid=%b data=%h busy=%b pop=%b required all 0",
                           o_valid, o_data, o_busy, o_fifo_pop);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) frame[i] = 16'($urandom);
    push_frame(0, 4);
    base = got_q.size();
    start_job(4, 2);
    wait_done(300, 1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_mid_done_timeout got no done required done"); end
    @(posedge clk); #1;
    build_expected(4, 2);
    checks++;
    if (got_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL reset_mid_count got %0d required %0d", got_q.size() - base, exp_q.size());
    end else
      for (int i = 0; i < exp_q.size(); i++)
        if (got_q[base + i] !== exp_q[i]) begin
          failures++; $display("FAIL reset_mid_seq idx %0d got %h required %h", i, got_q[base + i], exp_q[i]); break;
        end
    $display("reset mid-pass then fresh job, transfers=%0d", got_q.size() - base);
  endtask

  task automatic test_random;
    int base, cv0, sv0, len, npass;
    bit ok;
    for (int j = 0; j < 4; j++) begin
      len = $urandom_range(1, 7);
      npass = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) frame[i] = 16'($urandom);
      push_frame(0, len);
      base = got_q.size(); cv0 = credit_viol; sv0 = stall_viol;
      start_job(len, npass);
      wait_done(600, 1'b1, ok);
      i_ready = 1'b1;
      checks++;
      if (!ok) begin failures++; $display("FAIL rand_done_timeout job %0d got no done required done", j); end
      @(posedge clk); #1;
      build_expected(len, npass);
      checks++;
      if (got_q.size() - base != exp_q.size()) begin
        failures++; $display("FAIL rand_count job %0d got %0d required %0d", j, got_q.size() - base, exp_q.size());
      end else
        for (int i = 0; i < exp_q.size(); i++)
          if (got_q[base + i] !== exp_q[i]) begin
            failures++; $display("FAIL rand_seq job %0d idx %0d got %h required %h", j, i, got_q[base + i], exp_q[i]); break;
          end
      checks++;
      if (credit_viol != cv0 || stall_viol != sv0) begin
        failures++; $display("FAIL rand_protocol job %0d got overruns=%0d changes=%0d required 0 0",
                             j, credit_viol - cv0, stall_viol - sv0);
      end
      $display("random job %0d len=%0d pass=%0d transfers=%0d", j, len, npass, got_q.size() - base);
    end
  endtask

  task automatic test_flush;
    checks++;
    if (flush_viol != 0) begin failures++; $display("FAIL flush_align got %0d misaligned cycles required 0", flush_viol); end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_degenerate(0, 2);
    test_degenerate(3, 0);
    test_start_while_busy();
    test_reset_mid();
    test_random();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
